slib_input_filter: RTL



---
 rtl/slib_input_filter_if.sv | 37 +++
 rtl/slib_input_filter.sv | 73 +++++++
 2 files changed

// File: rtl/slib_input_filter_if.sv
// rtl/slib_input_filter_if.sv - Sample/level/edge bundle of the input glitch filter.
// Build option: SLIB_INPUT_FILTER_GLITCH_CNT_EN adds CLR and GLITCH.
interface slib_input_filter_if;
   logic       CE;
   logic       D;
   logic       Q;
   logic       RISE;
   logic       FALL;
`ifdef SLIB_INPUT_FILTER_GLITCH_CNT_EN
   logic       CLR;
   logic [7:0] GLITCH;
`endif

   modport master (
`ifdef SLIB_INPUT_FILTER_GLITCH_CNT_EN
      output CLR,
      input  GLITCH,
`endif
      output CE,
      output D,
      input  Q,
      input  RISE,
      input  FALL
   );

   modport slave (
`ifdef SLIB_INPUT_FILTER_GLITCH_CNT_EN
      input  CLR,
      output GLITCH,
`endif
      input  CE,
      input  D,
      output Q,
      output RISE,
      output FALL
   );
endinterface

// File: rtl/slib_input_filter.sv
// rtl/slib_input_filter.sv - Hysteresis glitch filter with registered rise/fall pulses.
// Build option: SLIB_INPUT_FILTER_GLITCH_CNT_EN enables the saturating 8-bit disagreement counter.
module slib_input_filter #(
   parameter int SIZE      = 4,
   parameter bit RESET_VAL = 1'b1
) (
   input logic                 CLK,
   input logic                 RST,
   slib_input_filter_if.slave  f
);
   localparam int            W   = $clog2(SIZE + 1);
   localparam logic [W-1:0]  MAX = W'(SIZE);

   logic [W-1:0] iCount;
   logic [W-1:0] cnt_next;
   logic         q_r;
   logic         q_next;
   logic         rise_r;
   logic         fall_r;

   always_comb begin
      cnt_next = iCount;
      if (f.D && (iCount < MAX))
         cnt_next = iCount + 1'b1;
      else if (!f.D && (iCount != '0))
         cnt_next = iCount - 1'b1;
   end

   // Q only moves at the saturation points; in between it holds (hysteresis).
   always_comb begin
      q_next = q_r;
      if (cnt_next == MAX)
         q_next = 1'b1;
      else if (cnt_next == '0)
         q_next = 1'b0;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         iCount <= RESET_VAL ? MAX : '0;
         q_r    <= RESET_VAL;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else if (f.CE) begin
         iCount <= cnt_next;
         q_r    <= q_next;
         rise_r <= q_next & ~q_r;
         fall_r <= ~q_next & q_r;
      end else begin
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end
   end

   assign f.Q    = q_r;
   assign f.RISE = rise_r;
   assign f.FALL = fall_r;

`ifdef SLIB_INPUT_FILTER_GLITCH_CNT_EN
   logic [7:0] glitch_r;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         glitch_r <= 8'd0;
      else if (f.CLR)
         glitch_r <= 8'd0;
      else if (f.CE && (f.D != q_r) && (glitch_r != 8'hFF))
         glitch_r <= glitch_r + 8'd1;
   end

   assign f.GLITCH = glitch_r;
`endif
endmodule
